// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Oversampling UART receiver. It takes one asynchronous frame (a start bit,
//   DATA_BITS data bits sent LSB first, and one stop bit) off the serial line and
//   presents the byte in a valid/ready holding register. The receiver flags
//   framing errors and overruns. It ignores short low glitches on an idle line.
//
//   Ports
//     clk                system clock, rising edge
//     rst_n              asynchronous active-low reset
//     I_baudrate_rx_clk  1-cycle enable at OVERSAMPLE x baud
//     I_rx_en            receiver enable; low forces IDLE
//     I_rxd              asynchronous serial line, idle high
//     I_rx_ready         consumer accepts O_rx_data while O_rx_valid is high
//     O_rx_data          received byte, stable while O_rx_valid is high
//     O_rx_valid         holding register full
//     O_frame_err        1-clk pulse: stop bit sampled low
//     O_overrun_err      1-clk pulse: good frame dropped, register still full
//     O_rx_busy          FSM is not in IDLE
//
//   state | meaning
//   IDLE  | waiting for a low level on the synchronised line
//   START | counting to the middle of the start bit to confirm it
//   DATA  | sampling each data bit at its middle
//   STOP  | sampling the stop bit, then loading or flagging
//   BREAK | line held low after a framing error; wait for it to go high
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 I_baudrate_rx_clk,
    input  logic                 I_rx_en,
    input  logic                 I_rxd,
    input  logic                 I_rx_ready,
    output logic [DATA_BITS-1:0] O_rx_data,
    output logic                 O_rx_valid,
    output logic                 O_frame_err,
    output logic                 O_overrun_err,
    output logic                 O_rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [TW-1:0]         tcnt, tcnt_nxt;
    logic [BW-1:0]         bidx, bidx_nxt;
    logic [DATA_BITS-1:0]  shreg, shreg_nxt;
    logic                  rxd_m, rxd_s;
    logic                  stop_ok, stop_bad, load;

    // The synchroniser resets to the idle-high level so that reset release is not
    // seen as a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= I_rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
            bidx  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
            bidx  <= bidx_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        bidx_nxt  = bidx;
        shreg_nxt = shreg;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        if (!I_rx_en) begin
            state_nxt = IDLE;
            tcnt_nxt  = '0;
            bidx_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nxt = START;
                        tcnt_nxt  = '0;
                    end
                end
                START: begin
                    if (I_baudrate_rx_clk) begin
                        if (tcnt == T_HALF) begin
                            tcnt_nxt  = '0;
                            bidx_nxt  = '0;
                            state_nxt = rxd_s ? IDLE : DATA;
                        end else begin
                            tcnt_nxt = tcnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (I_baudrate_rx_clk) begin
                        if (tcnt == T_LAST) begin
                            shreg_nxt[bidx] = rxd_s;
                            tcnt_nxt        = '0;
                            if (bidx == B_LAST) begin
                                bidx_nxt  = '0;
                                state_nxt = STOP;
                            end else begin
                                bidx_nxt = bidx + 1'b1;
                            end
                        end else begin
                            tcnt_nxt = tcnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (I_baudrate_rx_clk) begin
                        if (tcnt == T_LAST) begin
                            tcnt_nxt = '0;
                            if (rxd_s) begin
                                stop_ok   = 1'b1;
                                state_nxt = IDLE;
                            end else begin
                                stop_bad  = 1'b1;
                                state_nxt = BREAK;
                            end
                        end else begin
                            tcnt_nxt = tcnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rxd_s) state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    tcnt_nxt  = '0;
                    bidx_nxt  = '0;
                end
            endcase
        end
    end

    // A load is allowed when the register is empty or is being drained in the same
    // cycle. In that case the new byte replaces the accepted one.
    assign load = stop_ok && (!O_rx_valid || I_rx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O_rx_data     <= '0;
            O_rx_valid    <= 1'b0;
            O_frame_err   <= 1'b0;
            O_overrun_err <= 1'b0;
        end else begin
            if (load) begin
                O_rx_data  <= shreg;
                O_rx_valid <= 1'b1;
            end else if (O_rx_valid && I_rx_ready) begin
                O_rx_valid <= 1'b0;
            end
            O_frame_err   <= stop_bad;
            O_overrun_err <= stop_ok && O_rx_valid && !I_rx_ready;
        end
    end

    assign O_rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       rx_en;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stop_start_cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int rise_cnt = 0;
    logic prev_tick = 1'b0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .I_baudrate_rx_clk (tick),
        .I_rx_en           (rx_en),
        .I_rxd             (rxd),
        .I_rx_ready        (rx_ready),
        .O_rx_data         (rx_data),
        .O_rx_valid        (rx_valid),
        .O_frame_err       (frame_err),
        .O_overrun_err     (overrun_err),
        .O_rx_busy         (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // The scoreboard pops on every accept. Each rising edge of valid must follow
    // a tick by one clock and must fall inside the stop bit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_cnt++;
            if (overrun_err) ovr_cnt++;
            if (rx_valid && !prev_valid) begin
                rise_cnt++;
                check("valid_after_tick", {31'd0, prev_tick}, 32'd1);
                check("valid_in_stop_window",
                      {31'd0, ((cyc - stop_start_cyc) >= 20) && ((cyc - stop_start_cyc) <= 50)}, 32'd1);
            end
            if (rx_valid && rx_ready) begin
                check("sb_not_empty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_tick  = tick;
        prev_valid = rx_valid;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic expect_byte);
        if (stop && expect_byte) exp_q.push_back(d);
        rxd = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clk(BIT_CLK);
        end
        stop_start_cyc = cyc;
        rxd = stop;
        wait_clk(BIT_CLK);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_en    = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        wait_clk(5);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_errs", {30'd0, frame_err, overrun_err}, 32'd0);
        rst_n = 1'b1;
        wait_clk(20);

        // 1) clean frame
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("t1_rises", rise_cnt, 32'd1);
        check("t1_no_err", ferr_cnt + ovr_cnt, 32'd0);

        // 2) short glitch
        rxd = 1'b0;
        wait_clk(24);
        check("t2_busy_in_glitch", {31'd0, rx_busy}, 32'd1);
        rxd = 1'b1;
        wait_clk(BIT_CLK);
        check("t2_idle", {31'd0, rx_busy}, 32'd0);
        check("t2_no_valid", rise_cnt, 32'd1);
        check("t2_no_err", ferr_cnt + ovr_cnt, 32'd0);

        // 3) bad stop bit followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clk(3 * BIT_CLK);
        check("t3_ferr", ferr_cnt, 32'd1);
        check("t3_break_busy", {31'd0, rx_busy}, 32'd1);
        rxd = 1'b1;
        wait_clk(8);
        check("t3_idle", {31'd0, rx_busy}, 32'd0);
        check("t3_no_valid", rise_cnt, 32'd1);
        wait_clk(BIT_CLK);

        // 4) overrun
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        check("t4_data_kept", {24'd0, rx_data}, 32'h11);
        check("t4_valid", {31'd0, rx_valid}, 32'd1);
        check("t4_ovr", ovr_cnt, 32'd1);
        rx_ready = 1'b1;
        wait_clk(4);
        check("t4_valid_clr", {31'd0, rx_valid}, 32'd0);
        wait_clk(BIT_CLK);

        // 5) back-to-back frames
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("t5_rises", rise_cnt, 32'd5);
        check("t5_sb_empty", exp_q.size(), 32'd0);
        check("t5_errs", ferr_cnt + ovr_cnt, 32'd2);

        // 6) reset during bit 4, then a full frame
        rxd = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'(8'h96 >> i);
            wait_clk(BIT_CLK);
        end
        rxd = 1'(8'h96 >> 4);
        wait_clk(32);
        rst_n = 1'b0;
        wait_clk(4);
        check("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
        rxd = 1'b1;
        rst_n = 1'b1;
        wait_clk(2 * BIT_CLK);
        check("t6_no_partial", rise_cnt, 32'd5);
        send_frame(8'h96, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        check("t6_rises", rise_cnt, 32'd6);
        check("final_sb_empty", exp_q.size(), 32'd0);
        check("final_ferr", ferr_cnt, 32'd1);
        check("final_ovr", ovr_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
